// File: rtl/gpr_wb_pkg.sv
// Shared constants and types for the general-purpose register file write-back controller.
package gpr_wb_pkg;

    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned NUM_REGS = 32;

    localparam logic [ADDR_W-1:0] REG_ZERO  = 5'd0;
    localparam logic [ADDR_W-1:0] REG_OVF   = 5'd30;
    localparam logic [ADDR_W-1:0] REG_LINK  = 5'd31;
    localparam logic [DATA_W-1:0] OVF_VALUE = 32'd1;

    typedef enum logic [2:0] {
        SRC_NONE = 3'd0,
        SRC_LINK,
        SRC_OVF,
        SRC_ALU,
        SRC_MEM
    } wbSrc_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wbEntry_t;

endpackage

// File: rtl/wb_fifo.sv
// Load-return buffer: DEPTH entries of {addr, data}, registered empty/ready flags.
module wb_fifo
    import gpr_wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     push,
    input  wbEntry_t pushEntry,
    input  logic     pop,
    output wbEntry_t head,
    output logic     empty,
    output logic     ready
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    wbEntry_t         store [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] countNext;
    logic             doPush;
    logic             doPop;

    assign doPush = push && ready;
    assign doPop  = pop && !empty;
    assign head   = store[rdPtr];

    always_comb begin
        countNext = count;
        case ({doPush, doPop})
            2'b10:   countNext = count + CNT_W'(1);
            2'b01:   countNext = count - CNT_W'(1);
            default: countNext = count;
        endcase
    end

    // Flags are registered from the post-update count so they track it exactly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            empty <= 1'b1;
            ready <= 1'b1;
        end else begin
            if (doPush) wrPtr <= wrPtr + PTR_W'(1);
            if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
            count <= countNext;
            empty <= (countNext == CNT_W'(0));
            ready <= (countNext != CNT_W'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) store[wrPtr] <= pushEntry;
    end

endmodule

// File: rtl/gpr_wb_ctrl.sv
// Write-side sequencer for the register file: fixed-priority arbitration of link,
// overflow, ALU and buffered load returns, plus the pending-load scoreboard.
module gpr_wb_ctrl
    import gpr_wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                alu_valid,
    input  logic [ADDR_W-1:0]   alu_addr,
    input  logic [DATA_W-1:0]   alu_data,
    output logic                alu_ready,
    input  logic                lw_issue,
    input  logic [ADDR_W-1:0]   lw_issue_addr,
    input  logic                mem_valid,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_data,
    output logic                mem_ready,
    input  logic                link_valid,
    input  logic [DATA_W-1:0]   link_data,
    input  logic                ovf_valid,
    output logic                RegWrite,
    output logic [ADDR_W-1:0]   writeAddr,
    output logic [DATA_W-1:0]   writeData,
    output logic [NUM_REGS-1:0] pend_mask
);

    wbSrc_t              src;
    logic [ADDR_W-1:0]   winAddr;
    logic [DATA_W-1:0]   winData;
    logic                doWrite;
    logic                ovfPend;
    logic                ovfPendNext;
    logic                fifoPop;
    logic                fifoEmpty;
    logic                fifoReady;
    wbEntry_t            fifoHead;
    wbEntry_t            memEntry;
    logic [NUM_REGS-1:0] pendSet;
    logic [NUM_REGS-1:0] pendClr;
    logic [NUM_REGS-1:0] pendNext;

    // The pend_mask term keeps ALU writes ordered behind outstanding loads (WAW).
    assign alu_ready = !link_valid && !ovfPend && !pend_mask[alu_addr];
    assign mem_ready = fifoReady;
    assign memEntry  = '{addr: mem_addr, data: mem_data};

    wb_fifo #(
        .DEPTH (DEPTH)
    ) uFifo (
        .clk       (clk),
        .reset     (reset),
        .push      (mem_valid),
        .pushEntry (memEntry),
        .pop       (fifoPop),
        .head      (fifoHead),
        .empty     (fifoEmpty),
        .ready     (fifoReady)
    );

    always_comb begin
        src         = SRC_NONE;
        winAddr     = REG_ZERO;
        winData     = '0;
        pendSet     = '0;
        pendClr     = '0;

        if (link_valid) begin
            src     = SRC_LINK;
            winAddr = REG_LINK;
            winData = link_data;
        end else if (ovfPend) begin
            src     = SRC_OVF;
            winAddr = REG_OVF;
            winData = OVF_VALUE;
        end else if (alu_valid && alu_ready) begin
            src     = SRC_ALU;
            winAddr = alu_addr;
            winData = alu_data;
        end else if (!fifoEmpty) begin
            src     = SRC_MEM;
            winAddr = fifoHead.addr;
            winData = fifoHead.data;
        end

        fifoPop = (src == SRC_MEM);
        // $0 requests are consumed but never reach the register file.
        doWrite = (src != SRC_NONE) && (winAddr != REG_ZERO);

        // A new overflow in the issuing cycle re-arms the flag.
        ovfPendNext = ovf_valid || (ovfPend && (src != SRC_OVF));

        if (fifoPop)  pendClr[fifoHead.addr] = 1'b1;
        if (lw_issue) pendSet[lw_issue_addr] = 1'b1;
        pendSet[REG_ZERO] = 1'b0;
        pendNext = (pend_mask & ~pendClr) | pendSet;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            RegWrite  <= 1'b0;
            writeAddr <= '0;
            writeData <= '0;
            ovfPend   <= 1'b0;
            pend_mask <= '0;
        end else begin
            RegWrite <= doWrite;
            if (doWrite) begin
                writeAddr <= winAddr;
                writeData <= winData;
            end
            ovfPend   <= ovfPendNext;
            pend_mask <= pendNext;
        end
    end

endmodule

// File: tb/tb_gpr_wb_ctrl.sv
// Bench for gpr_wb_ctrl: vector table, directed multi-cycle sequences, random run vs reference model.
module tb_gpr_wb_ctrl;

    localparam int unsigned DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        aluValid;
    logic [4:0]  aluAddr;
    logic [31:0] aluData;
    logic        aluReady;
    logic        lwIssue;
    logic [4:0]  lwIssueAddr;
    logic        memValid;
    logic [4:0]  memAddr;
    logic [31:0] memData;
    logic        memReady;
    logic        linkValid;
    logic [31:0] linkData;
    logic        ovfValid;
    logic        regWrite;
    logic [4:0]  writeAddr;
    logic [31:0] writeData;
    logic [31:0] pendMask;

    int nTests = 0;
    int nFail  = 0;

    typedef struct {
        logic        link;
        logic [31:0] linkData;
        logic        ovf;
        logic        alu;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        mem;
        logic        expReady;
        logic        expRw;
        logic [4:0]  expAddr;
        logic [31:0] expData;
    } vec_t;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    vec_t        vecs [8];
    ent_t        mQ [$];
    ent_t        ent;
    logic [31:0] mPend;
    logic        mOvf;
    logic        mRw;
    logic [4:0]  mAddr;
    logic [31:0] mData;
    logic        expReady;
    logic        won;
    logic        ovfIssued;
    logic        pushOk;
    logic [4:0]  wa;
    logic [31:0] wd;
    int          aluWait;

    gpr_wb_ctrl #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .alu_valid     (aluValid),
        .alu_addr      (aluAddr),
        .alu_data      (aluData),
        .alu_ready     (aluReady),
        .lw_issue      (lwIssue),
        .lw_issue_addr (lwIssueAddr),
        .mem_valid     (memValid),
        .mem_addr      (memAddr),
        .mem_data      (memData),
        .mem_ready     (memReady),
        .link_valid    (linkValid),
        .link_data     (linkData),
        .ovf_valid     (ovfValid),
        .RegWrite      (regWrite),
        .writeAddr     (writeAddr),
        .writeData     (writeData),
        .pend_mask     (pendMask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic checkWr(input string tag, input logic rw, input logic [4:0] a, input logic [31:0] d);
        check1({tag, ".RegWrite"}, regWrite, rw);
        check({tag, ".writeAddr"}, 32'(writeAddr), 32'(a));
        check({tag, ".writeData"}, writeData, d);
    endtask

    task automatic idleInputs();
        aluValid    = 1'b0; aluAddr  = '0; aluData  = '0;
        lwIssue     = 1'b0; lwIssueAddr = '0;
        memValid    = 1'b0; memAddr  = '0; memData  = '0;
        linkValid   = 1'b0; linkData = '0;
        ovfValid    = 1'b0;
    endtask

    task automatic doReset();
        idleInputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idleInputs();
        #2;
        checkWr("reset", 1'b0, 5'd0, 32'd0);
        check("reset.pend_mask", pendMask, 32'd0);
        tick();
        reset = 1'b0;
        #1;
        check1("reset.mem_ready", memReady, 1'b1);

        // Single-cycle vectors from a clean state: ready and first write.
        vecs[0] = '{1'b0, 32'h0,        1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b1, 1'b1, 5'd5,  32'hDEADBEEF};
        vecs[1] = '{1'b1, 32'h00400010, 1'b0, 1'b1, 5'd7, 32'h01020304, 1'b0, 1'b0, 1'b1, 5'd31, 32'h00400010};
        vecs[2] = '{1'b0, 32'h0,        1'b0, 1'b1, 5'd0, 32'h11111111, 1'b0, 1'b1, 1'b0, 5'd0,  32'h0};
        vecs[3] = '{1'b0, 32'h0,        1'b0, 1'b0, 5'd9, 32'h0,        1'b0, 1'b1, 1'b0, 5'd0,  32'h0};
        vecs[4] = '{1'b0, 32'h0,        1'b1, 1'b1, 5'd6, 32'h66666666, 1'b0, 1'b1, 1'b1, 5'd6,  32'h66666666};
        vecs[5] = '{1'b1, 32'hABCD0000, 1'b1, 1'b0, 5'd2, 32'h0,        1'b0, 1'b0, 1'b1, 5'd31, 32'hABCD0000};
        vecs[6] = '{1'b0, 32'h0,        1'b0, 1'b0, 5'd4, 32'h44444444, 1'b1, 1'b1, 1'b0, 5'd0,  32'h0};
        vecs[7] = '{1'b1, 32'h0,        1'b0, 1'b1, 5'd0, 32'h77777777, 1'b0, 1'b0, 1'b1, 5'd31, 32'h0};
        for (int i = 0; i < 8; i++) begin
            doReset();
            linkValid = vecs[i].link; linkData = vecs[i].linkData;
            ovfValid  = vecs[i].ovf;
            aluValid  = vecs[i].alu;  aluAddr  = vecs[i].addr; aluData = vecs[i].data;
            memValid  = vecs[i].mem;  memAddr  = vecs[i].addr; memData = vecs[i].data;
            #1;
            check1($sformatf("vec%0d.alu_ready", i), aluReady, vecs[i].expReady);
            tick();
            idleInputs();
            checkWr($sformatf("vec%0d", i), vecs[i].expRw, vecs[i].expAddr, vecs[i].expData);
            check($sformatf("vec%0d.pend_mask", i), pendMask, 32'd0);
        end

        // Link, overflow and ALU together: $31, then $30, then ALU.
        doReset();
        linkValid = 1'b1; linkData = 32'h00400010; ovfValid = 1'b1;
        aluValid = 1'b1; aluAddr = 5'd3; aluData = 32'hA5A5A5A5;
        #1; check1("prio.ready0", aluReady, 1'b0);
        tick();
        linkValid = 1'b0; ovfValid = 1'b0;
        checkWr("prio.w1", 1'b1, 5'd31, 32'h00400010);
        #1; check1("prio.ready1", aluReady, 1'b0);
        tick();
        checkWr("prio.w2", 1'b1, 5'd30, 32'd1);
        #1; check1("prio.ready2", aluReady, 1'b1);
        tick();
        aluValid = 1'b0;
        checkWr("prio.w3", 1'b1, 5'd3, 32'hA5A5A5A5);
        tick();
        checkWr("prio.idle", 1'b0, 5'd3, 32'hA5A5A5A5);

        // Load scoreboard: ALU write to a pending register waits behind the load.
        doReset();
        lwIssue = 1'b1; lwIssueAddr = 5'd8;
        tick();
        lwIssue = 1'b0;
        check("sb.pend_set", pendMask, 32'h00000100);
        aluValid = 1'b1; aluAddr = 5'd8; aluData = 32'hCAFEF00D;
        #1; check1("sb.ready_blocked", aluReady, 1'b0);
        tick();
        check1("sb.no_write", regWrite, 1'b0);
        memValid = 1'b1; memAddr = 5'd8; memData = 32'h12345678;
        tick();
        memValid = 1'b0;
        check1("sb.fifo_latency", regWrite, 1'b0);
        tick();
        checkWr("sb.load", 1'b1, 5'd8, 32'h12345678);
        check("sb.pend_clr", pendMask, 32'd0);
        #1; check1("sb.ready_free", aluReady, 1'b1);
        tick();
        aluValid = 1'b0;
        checkWr("sb.alu", 1'b1, 5'd8, 32'hCAFEF00D);

        // Fill the FIFO behind a held link, then drain in order.
        doReset();
        linkValid = 1'b1; linkData = 32'h00000100;
        for (int i = 0; i < int'(DEPTH); i++) begin
            memValid = 1'b1; memAddr = 5'(10 + i); memData = 32'h1000 + 32'(i);
            #1; check1($sformatf("fill%0d.mem_ready", i), memReady, 1'b1);
            tick();
            checkWr($sformatf("fill%0d", i), 1'b1, 5'd31, 32'h00000100);
        end
        check1("fill.full", memReady, 1'b0);
        memAddr = 5'd20; memData = 32'hBAD0BAD0;
        tick();
        check1("fill.still_full", memReady, 1'b0);
        linkValid = 1'b0; memValid = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            tick();
            checkWr($sformatf("drain%0d", i), 1'b1, 5'(10 + i), 32'h1000 + 32'(i));
            check1($sformatf("drain%0d.mem_ready", i), memReady, 1'b1);
        end
        tick();
        checkWr("drain.empty", 1'b0, 5'd13, 32'h1003);

        // $0 requests are consumed without a write.
        doReset();
        aluValid = 1'b1; aluAddr = 5'd0; aluData = 32'hFFFFFFFF;
        memValid = 1'b1; memAddr = 5'd0; memData = 32'h00000077;
        #1; check1("zero.alu_ready", aluReady, 1'b1);
        tick();
        idleInputs();
        checkWr("zero.alu", 1'b0, 5'd0, 32'd0);
        tick();
        checkWr("zero.mem", 1'b0, 5'd0, 32'd0);
        tick();
        checkWr("zero.after", 1'b0, 5'd0, 32'd0);
        check1("zero.mem_ready", memReady, 1'b1);

        // Reset with buffered returns and a pending overflow.
        doReset();
        linkValid = 1'b1; linkData = 32'h55; ovfValid = 1'b1;
        lwIssue = 1'b1; lwIssueAddr = 5'd12;
        memValid = 1'b1; memAddr = 5'd12; memData = 32'hAB;
        tick();
        lwIssue = 1'b0; ovfValid = 1'b0; memAddr = 5'd13;
        tick();
        memAddr = 5'd14;
        tick();
        checkWr("rst.pre", 1'b1, 5'd31, 32'h55);
        check("rst.pre_pend", pendMask, 32'h00001000);
        memValid = 1'b0; linkValid = 1'b0;
        reset = 1'b1;
        #1;
        checkWr("rst.async", 1'b0, 5'd0, 32'd0);
        check("rst.pend", pendMask, 32'd0);
        check1("rst.mem_ready", memReady, 1'b1);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkWr($sformatf("rst.post%0d", i), 1'b0, 5'd0, 32'd0);
        end

        // Random traffic against the reference model.
        doReset();
        mQ.delete();
        mPend = '0; mOvf = 1'b0; mRw = 1'b0; mAddr = '0; mData = '0;
        aluWait = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            linkValid   = ($urandom_range(7) == 0);
            linkData    = $urandom();
            ovfValid    = ($urandom_range(15) == 0);
            lwIssue     = ($urandom_range(5) == 0);
            lwIssueAddr = 5'($urandom());
            if (!aluValid && $urandom_range(1) == 1) begin
                aluValid = 1'b1;
                aluAddr  = 5'($urandom());
                aluData  = $urandom();
                aluWait  = 0;
            end
            memValid = ($urandom_range(2) == 0);
            memAddr  = ($urandom_range(1) == 1) ? aluAddr : 5'($urandom());
            memData  = $urandom();
            #1;
            expReady = !linkValid && !mOvf && !mPend[aluAddr];
            check1("rand.alu_ready", aluReady, expReady);
            check1("rand.mem_ready", memReady, mQ.size() != int'(DEPTH));

            pushOk    = memValid && (mQ.size() != int'(DEPTH));
            won       = 1'b1;
            ovfIssued = 1'b0;
            wa        = '0;
            wd        = '0;
            if (linkValid) begin
                wa = 5'd31; wd = linkData;
            end else if (mOvf) begin
                wa = 5'd30; wd = 32'd1; ovfIssued = 1'b1;
            end else if (aluValid && expReady) begin
                wa = aluAddr; wd = aluData;
            end else if (mQ.size() != 0) begin
                ent = mQ.pop_front();
                wa = ent.a; wd = ent.d;
                mPend[ent.a] = 1'b0;
            end else begin
                won = 1'b0;
            end
            if (lwIssue && lwIssueAddr != 5'd0) mPend[lwIssueAddr] = 1'b1;
            if (pushOk) mQ.push_back('{a: memAddr, d: memData});
            mOvf = ovfValid || (mOvf && !ovfIssued);
            if (won && wa != 5'd0) begin
                mRw = 1'b1; mAddr = wa; mData = wd;
            end else begin
                mRw = 1'b0;
            end

            tick();
            checkWr("rand", mRw, mAddr, mData);
            check("rand.pend_mask", pendMask, mPend);

            if (aluValid && expReady) aluValid = 1'b0;
            else if (aluValid && ++aluWait > 16) aluValid = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/gpr_wb_ctrl.md
Name: gpr_wb_ctrl

Overview:
- Write-side sequencer for the 32x32 general-purpose register file.
- Collects register-write requests from four sources: ALU result, load return, jal link and the overflow flag.
- Serialises them onto the register file's single write port (RegWrite, writeAddr, writeData) with fixed priority.
- Buffers load returns in a small FIFO and keeps a pending-load scoreboard so the pipeline can stall on RAW/WAW hazards.

Parameters:
- DEPTH, 4, load-return FIFO entries; must be a power of 2, minimum 2.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- alu_valid  in  1  ALU write request.
- alu_addr  in  5  ALU destination register.
- alu_data  in  32  ALU result.
- alu_ready  out  1  ALU request accepted this cycle.
- lw_issue  in  1  load issued; marks its destination pending.
- lw_issue_addr  in  5  load destination register.
- mem_valid  in  1  load data return.
- mem_addr  in  5  load return destination.
- mem_data  in  32  load return data.
- mem_ready  out  1  FIFO can accept a return.
- link_valid  in  1  jal link write to $31.
- link_data  in  32  link address.
- ovf_valid  in  1  overflow event; sets $30 to 1.
- RegWrite  out  1  register file write enable (registered).
- writeAddr  out  5  register file write address (registered).
- writeData  out  32  register file write data (registered).
- pend_mask  out  32  bit n=1 means a load to $n is outstanding.

Behaviour:
- Reset (async, active-high): RegWrite=0, writeAddr=0, writeData=0, pend_mask=0, FIFO empty, ovf_pend=0.
- After reset, mem_ready=1; alu_ready is then combinational per the rule below.
- Write port arbitration, evaluated each cycle, highest first:
  - 1. link_valid: writes $31 <= link_data. Always accepted; link has no ready signal.
  - 2. ovf_pend: writes $30 <= 32'd1.
  - 3. alu_valid && alu_ready.
  - 4. FIFO head.
- The winner drives the registered outputs at the next rising edge. Latency from request to RegWrite is one cycle; a FIFO entry takes at least 2 cycles.
- No winner: RegWrite=0 next cycle. writeAddr/writeData hold their previous values.
- ovf_pend:
  - set by ovf_valid, cleared when the $30 write is issued;
  - repeated ovf_valid while pending merges into one write;
  - set and issue in the same cycle leaves it set.
- alu_ready = !link_valid && !ovf_pend && !pend_mask[alu_addr]. Combinational; the source holds its request until accepted. The pend_mask term enforces WAW ordering behind outstanding loads.
- FIFO:
  - push when mem_valid && mem_ready;
  - mem_ready = (count != DEPTH), registered from count;
  - push when full is not accepted; the source holds;
  - push and pop in the same cycle: count unchanged;
  - pointers wrap modulo DEPTH;
  - pop only when the FIFO wins arbitration.
- Scoreboard:
  - lw_issue sets pend_mask[lw_issue_addr];
  - a FIFO pop clears pend_mask[head addr];
  - set and clear of the same bit in one cycle: set wins;
  - bit 0 is never set.
- Address 0:
  - any request to $0 is accepted and consumed (FIFO pop, alu_ready handshake) but issues RegWrite=0;
  - $0 is never written.
- Reset mid-operation: FIFO contents and pending writes are discarded; no partial write is emitted.
- Widths:
  - count is log2(DEPTH)+1 bits;
  - the $30 flag write is zero-extended to 32 bits.

Decomposition:
- Package gpr_wb_pkg holds:
  - constants REG_ZERO=5'd0, REG_OVF=5'd30, REG_LINK=5'd31, OVF_VALUE=32'd1;
  - source-select encoding SRC_NONE/SRC_LINK/SRC_OVF/SRC_ALU/SRC_MEM.
- Sub-module wb_fifo (DEPTH x 37-bit entries: addr+data; push/pop/full/empty/count).
- Arbitration and scoreboard stay in the top module.

Test Plan:
- Reset, then alu_valid with addr=5, data=32'hDEADBEEF -> next cycle RegWrite=1, writeAddr=5, writeData=32'hDEADBEEF; pend_mask=0.
- Same cycle: link_valid (link_data=32'h00400010), ovf_valid and alu_valid (addr=3) -> cycle+1 writes $31=32'h00400010; cycle+2 writes $30=1; cycle+3 writes $3; alu_ready=0 for the first two cycles.
- lw_issue addr=8, then alu_valid addr=8 -> alu_ready=0. mem return addr=8, data=32'h12345678 -> write $8=32'h12345678 two cycles later, pend_mask[8]=0, then the ALU write to $8 follows.
- Fill FIFO with DEPTH returns while link_valid is held high -> mem_ready=0 after the 4th push. Drop link_valid -> entries drain in order, one per cycle, mem_ready=1 after the first pop.
- alu_valid addr=0 and mem return addr=0 -> both consumed, RegWrite stays 0, FIFO empty.
- Reset asserted with 3 FIFO entries and ovf_pend set -> outputs 0 immediately, no write after release, mem_ready=1.
